ysyx_25020047_exu_mc: RTL and testbench

Multi-cycle, parametrised execute unit for the ysyx NPC core, sitting between IDU and WBU/LSU. It takes decoded operations over a valid/ready handshake and completes integer ALU ops in one cycle. RV32M multiply/divide runs on an iterative datapath. It returns a registered result with write-enable, jump target and halt/illegal flags. EBREAK becomes a sticky halt output rather than a combinational simulation stop.

---
 rtl/ysyx_25020047_exu_pkg.sv | 32 +++
 rtl/ysyx_25020047_muldiv.sv | 131 +++++++++++++
 rtl/ysyx_25020047_exu_mc.sv | 185 ++++++++++++++++++
 tb/tb_ysyx_25020047_exu_mc.sv | 188 ++++++++++++++++++
 4 files changed

// File: rtl/ysyx_25020047_exu_pkg.sv
`default_nettype none
// ============================================================================
// Module   : ysyx_25020047_exu_pkg
// Brief    : Op/state encodings and constants shared by the EXU and its engine.
// Revision : 1.0
// ============================================================================
package ysyx_25020047_exu_pkg;

    localparam int OP_ENC_W      = 5;
    localparam int JALR_LINK_OFS = 4;

    typedef enum logic [OP_ENC_W-1:0] {
        OP_ADD    = 5'd0,  OP_SUB   = 5'd1,  OP_AND   = 5'd2,  OP_OR     = 5'd3,
        OP_XOR    = 5'd4,  OP_SLL   = 5'd5,  OP_SRL   = 5'd6,  OP_SRA    = 5'd7,
        OP_SLT    = 5'd8,  OP_SLTU  = 5'd9,  OP_LUI   = 5'd10, OP_AUIPC  = 5'd11,
        OP_JALR   = 5'd12, OP_EBREAK = 5'd13, OP_MUL  = 5'd14, OP_MULH   = 5'd15,
        OP_MULHU  = 5'd16, OP_MULHSU = 5'd17, OP_DIV  = 5'd18, OP_DIVU   = 5'd19,
        OP_REM    = 5'd20, OP_REMU  = 5'd21
    } op_e;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_CALC = 1'b1
    } state_e;

    typedef enum logic [2:0] {
        MD_MUL = 3'd0, MD_MULH = 3'd1, MD_MULHU = 3'd2, MD_MULHSU = 3'd3,
        MD_DIV = 3'd4, MD_DIVU = 3'd5, MD_REM   = 3'd6, MD_REMU   = 3'd7
    } md_op_e;

endpackage
`default_nettype wire

// File: rtl/ysyx_25020047_muldiv.sv
`default_nettype none
// ============================================================================
// Module   : ysyx_25020047_muldiv
// Brief    : Iterative shift-add multiplier / restoring divider, one bit per cycle.
// Revision : 1.0
// ============================================================================
module ysyx_25020047_muldiv
    import ysyx_25020047_exu_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  md_op_e          op,
    input  logic [XLEN-1:0] src1,
    input  logic [XLEN-1:0] src2,
    output logic            fast,
    output logic [XLEN-1:0] fast_result,
    output logic            done,
    output logic [XLEN-1:0] result
);

    localparam int CNT_W = $clog2(XLEN);
    localparam logic [XLEN-1:0] MIN_INT = {1'b1, {(XLEN-1){1'b0}}};

    logic             active_q, active_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    md_op_e           op_q, op_d;
    logic             neg_q, neg_d;
    logic [XLEN-1:0]  hi_q, hi_d, lo_q, lo_d, b_q, b_d;

    logic            is_div, is_rem, signed_div, neg1, neg2;
    logic [XLEN-1:0] mag1, mag2;
    logic            q_is_div, q_is_rem, ok;
    logic [XLEN:0]   acc, r_sh;
    logic [XLEN-1:0] hi_n, lo_n, div_v;
    logic [2*XLEN-1:0] prod, prod_s;

    // Operand conditioning and the single-cycle division corner cases
    always_comb begin
        is_div     = op inside {MD_DIV, MD_DIVU, MD_REM, MD_REMU};
        is_rem     = op inside {MD_REM, MD_REMU};
        signed_div = op inside {MD_DIV, MD_REM};
        neg1       = (signed_div || op inside {MD_MULH, MD_MULHSU}) && src1[XLEN-1];
        neg2       = (signed_div || op == MD_MULH) && src2[XLEN-1];
        mag1       = neg1 ? -src1 : src1;
        mag2       = neg2 ? -src2 : src2;
        fast        = 1'b0;
        fast_result = '0;
        if (is_div && src2 == '0) begin
            fast        = 1'b1;
            fast_result = is_rem ? src1 : '1;
        end else if (signed_div && src1 == MIN_INT && src2 == '1) begin
            fast        = 1'b1;
            fast_result = is_rem ? '0 : src1;
        end
    end

    always_comb begin
        q_is_div = op_q inside {MD_DIV, MD_DIVU, MD_REM, MD_REMU};
        q_is_rem = op_q inside {MD_REM, MD_REMU};
        acc  = {1'b0, hi_q} + (lo_q[0] ? {1'b0, b_q} : '0);
        r_sh = {hi_q, lo_q[XLEN-1]};
        ok   = r_sh >= {1'b0, b_q};
        if (q_is_div) begin
            hi_n = ok ? (r_sh[XLEN-1:0] - b_q) : r_sh[XLEN-1:0];
            lo_n = {lo_q[XLEN-2:0], ok};
        end else begin
            hi_n = acc[XLEN:1];
            lo_n = {acc[0], lo_q[XLEN-1:1]};
        end
        prod   = {hi_n, lo_n};
        prod_s = neg_q ? -prod : prod;
        div_v  = q_is_rem ? hi_n : lo_n;
        if (q_is_div)
            result = neg_q ? -div_v : div_v;
        else if (op_q == MD_MUL)
            result = prod_s[XLEN-1:0];
        else
            result = prod_s[2*XLEN-1:XLEN];
        done = active_q && (cnt_q == '0);
    end

    always_comb begin
        active_d = active_q;
        cnt_d    = cnt_q;
        op_d     = op_q;
        neg_d    = neg_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        b_d      = b_q;
        if (start) begin
            active_d = 1'b1;
            cnt_d    = CNT_W'(XLEN-1);
            op_d     = op;
            neg_d    = is_rem ? neg1 : (neg1 ^ neg2);
            hi_d     = '0;
            lo_d     = is_div ? mag1 : mag2;
            b_d      = is_div ? mag2 : mag1;
        end else if (active_q) begin
            hi_d  = hi_n;
            lo_d  = lo_n;
            cnt_d = cnt_q - CNT_W'(1);
            if (cnt_q == '0)
                active_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            active_q <= 1'b0;
            cnt_q    <= '0;
            op_q     <= MD_MUL;
            neg_q    <= 1'b0;
            hi_q     <= '0;
            lo_q     <= '0;
            b_q      <= '0;
        end else begin
            active_q <= active_d;
            cnt_q    <= cnt_d;
            op_q     <= op_d;
            neg_q    <= neg_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
            b_q      <= b_d;
        end
    end

endmodule
`default_nettype wire

// File: rtl/ysyx_25020047_exu_mc.sv
`default_nettype none
// ============================================================================
// Module   : ysyx_25020047_exu_mc
// Brief    : Multi-cycle execute unit: 1-cycle ALU, iterative M-extension, sticky halt.
// Revision : 1.0
// ============================================================================
module ysyx_25020047_exu_mc
    import ysyx_25020047_exu_pkg::*;
#(
    parameter int XLEN = 32,
    parameter int OP_W = 5
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [OP_W-1:0] in_op,
    input  logic            in_use_imm,
    input  logic [XLEN-1:0] in_src1,
    input  logic [XLEN-1:0] in_src2,
    input  logic [XLEN-1:0] in_imm,
    input  logic [XLEN-1:0] in_pc,
    input  logic [4:0]      in_rd,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_result,
    output logic [XLEN-1:0] out_target,
    output logic [4:0]      out_rd,
    output logic            out_wen,
    output logic            out_halt,
    output logic            out_illegal,
    output logic            busy
);

    localparam int SH_W = $clog2(XLEN);

    state_e          state_q, state_d;
    logic            out_valid_q, out_valid_d, out_wen_q, out_wen_d;
    logic            out_illegal_q, out_illegal_d, halted_q, halted_d;
    logic [XLEN-1:0] out_result_q, out_result_d, out_target_q, out_target_d;
    logic [4:0]      out_rd_q, out_rd_d, pend_rd_q, pend_rd_d;

    logic [XLEN-1:0] opb, alu_result, alu_target, md_fast_result, md_result;
    logic            alu_wen, alu_halt, alu_illegal, is_md;
    logic            accept, md_start, md_fast, md_done;
    md_op_e          md_op;

    always_comb begin
        opb         = in_use_imm ? in_imm : in_src2;
        alu_result  = '0;
        alu_target  = '0;
        alu_wen     = 1'b1;
        alu_halt    = 1'b0;
        alu_illegal = 1'b0;
        is_md       = 1'b0;
        md_op       = MD_MUL;
        case (in_op)
            OP_W'(OP_ADD):    alu_result = in_src1 + opb;
            OP_W'(OP_SUB):    alu_result = in_src1 - opb;
            OP_W'(OP_AND):    alu_result = in_src1 & opb;
            OP_W'(OP_OR):     alu_result = in_src1 | opb;
            OP_W'(OP_XOR):    alu_result = in_src1 ^ opb;
            OP_W'(OP_SLL):    alu_result = in_src1 << opb[SH_W-1:0];
            OP_W'(OP_SRL):    alu_result = in_src1 >> opb[SH_W-1:0];
            OP_W'(OP_SRA):    alu_result = $unsigned($signed(in_src1) >>> opb[SH_W-1:0]);
            OP_W'(OP_SLT):    alu_result = {{(XLEN-1){1'b0}}, $signed(in_src1) < $signed(opb)};
            OP_W'(OP_SLTU):   alu_result = {{(XLEN-1){1'b0}}, in_src1 < opb};
            OP_W'(OP_LUI):    alu_result = in_imm;
            OP_W'(OP_AUIPC):  alu_result = in_pc + in_imm;
            OP_W'(OP_JALR): begin
                alu_result = in_pc + XLEN'(JALR_LINK_OFS);
                alu_target = (in_src1 + in_imm) & ~XLEN'(1);
            end
            OP_W'(OP_EBREAK): begin
                alu_wen  = 1'b0;
                alu_halt = 1'b1;
            end
            OP_W'(OP_MUL):    begin is_md = 1'b1; md_op = MD_MUL;    end
            OP_W'(OP_MULH):   begin is_md = 1'b1; md_op = MD_MULH;   end
            OP_W'(OP_MULHU):  begin is_md = 1'b1; md_op = MD_MULHU;  end
            OP_W'(OP_MULHSU): begin is_md = 1'b1; md_op = MD_MULHSU; end
            OP_W'(OP_DIV):    begin is_md = 1'b1; md_op = MD_DIV;    end
            OP_W'(OP_DIVU):   begin is_md = 1'b1; md_op = MD_DIVU;   end
            OP_W'(OP_REM):    begin is_md = 1'b1; md_op = MD_REM;    end
            OP_W'(OP_REMU):   begin is_md = 1'b1; md_op = MD_REMU;   end
            default: begin
                alu_wen     = 1'b0;
                alu_illegal = 1'b1;
            end
        endcase
    end

    ysyx_25020047_muldiv #(.XLEN(XLEN)) u_muldiv (
        .clk         (clk),
        .rst         (rst),
        .start       (md_start),
        .op          (md_op),
        .src1        (in_src1),
        .src2        (opb),
        .fast        (md_fast),
        .fast_result (md_fast_result),
        .done        (md_done),
        .result      (md_result)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= ST_IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (md_start) state_d = ST_CALC;
            ST_CALC: if (md_done)  state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        busy     = (state_q == ST_CALC);
        in_ready = (state_q == ST_IDLE) && !halted_q && (!out_valid_q || out_ready);
        accept   = in_valid && in_ready;
        md_start = accept && is_md && !md_fast;
    end

    // A new result may overwrite the register in the same cycle the old one drains
    always_comb begin
        out_valid_d   = out_valid_q && !out_ready;
        out_result_d  = out_result_q;
        out_target_d  = out_target_q;
        out_rd_d      = out_rd_q;
        out_wen_d     = out_wen_q;
        out_illegal_d = out_illegal_q;
        halted_d      = halted_q || (accept && alu_halt);
        pend_rd_d     = md_start ? in_rd : pend_rd_q;
        if (accept && !md_start) begin
            out_valid_d   = 1'b1;
            out_result_d  = is_md ? md_fast_result : alu_result;
            out_target_d  = alu_target;
            out_rd_d      = in_rd;
            out_wen_d     = alu_wen && (in_rd != 5'd0);
            out_illegal_d = alu_illegal;
        end else if (md_done) begin
            out_valid_d   = 1'b1;
            out_result_d  = md_result;
            out_target_d  = '0;
            out_rd_d      = pend_rd_q;
            out_wen_d     = (pend_rd_q != 5'd0);
            out_illegal_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid_q   <= 1'b0;
            out_result_q  <= '0;
            out_target_q  <= '0;
            out_rd_q      <= '0;
            out_wen_q     <= 1'b0;
            out_illegal_q <= 1'b0;
            halted_q      <= 1'b0;
            pend_rd_q     <= '0;
        end else begin
            out_valid_q   <= out_valid_d;
            out_result_q  <= out_result_d;
            out_target_q  <= out_target_d;
            out_rd_q      <= out_rd_d;
            out_wen_q     <= out_wen_d;
            out_illegal_q <= out_illegal_d;
            halted_q      <= halted_d;
            pend_rd_q     <= pend_rd_d;
        end
    end

    assign out_valid   = out_valid_q;
    assign out_result  = out_result_q;
    assign out_target  = out_target_q;
    assign out_rd      = out_rd_q;
    assign out_wen     = out_wen_q;
    assign out_illegal = out_illegal_q;
    assign out_halt    = halted_q;

endmodule
`default_nettype wire

// File: tb/tb_ysyx_25020047_exu_mc.sv
`default_nettype none
// ============================================================================
// Module   : tb_ysyx_25020047_exu_mc
// Brief    : Directed vector table plus hand-written backpressure/halt/reset sequences.
// Revision : 1.0
// ============================================================================
module tb_ysyx_25020047_exu_mc;
    import ysyx_25020047_exu_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0, in_use_imm = 1'b0, out_ready = 1'b1;
    logic [4:0]  in_op = '0, in_rd = '0;
    logic [31:0] in_src1 = '0, in_src2 = '0, in_imm = '0, in_pc = '0;
    logic        in_ready, out_valid, out_wen, out_halt, out_illegal, busy;
    logic [31:0] out_result, out_target;
    logic [4:0]  out_rd;

    int n_cmp  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    ysyx_25020047_exu_mc #(.XLEN(32), .OP_W(5)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op), .in_use_imm(in_use_imm),
        .in_src1(in_src1), .in_src2(in_src2), .in_imm(in_imm), .in_pc(in_pc), .in_rd(in_rd),
        .out_valid(out_valid), .out_ready(out_ready), .out_result(out_result),
        .out_target(out_target), .out_rd(out_rd), .out_wen(out_wen),
        .out_halt(out_halt), .out_illegal(out_illegal), .busy(busy)
    );

    typedef struct {
        logic [4:0]  op;
        logic        ui;
        logic [31:0] s1, s2, imm, pc;
        logic [4:0]  rd;
        logic [31:0] res, tgt;
        logic        wen, ill;
        int          lat, bcnt;
    } vec_t;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
        end
    endtask

    // Called on a negedge: presents one request, returns cycles until out_valid and busy count
    task automatic issue(input logic [4:0] op, input logic ui, input logic [31:0] s1,
                         input logic [31:0] s2, input logic [31:0] imm, input logic [31:0] pc,
                         input logic [4:0] rd, output int lat, output int bcnt);
        in_valid = 1'b1; in_op = op; in_use_imm = ui;
        in_src1 = s1; in_src2 = s2; in_imm = imm; in_pc = pc; in_rd = rd;
        chk("in_ready_at_issue", {31'b0, in_ready}, 32'd1);
        @(negedge clk);
        in_valid = 1'b0;
        lat  = 1;
        bcnt = 0;
        while (!out_valid && lat < 100) begin
            if (busy) bcnt++;
            @(negedge clk);
            lat++;
        end
    endtask

    vec_t vt[27];
    int   lat, bcnt;

    initial begin
        vt[0]  = '{OP_ADD,   1'b1, 32'd5, 32'd0, 32'hFFFFFFFD, 32'd0, 5'd3, 32'd2, 32'd0, 1'b1, 1'b0, 1, 0};
        vt[1]  = '{OP_ADD,   1'b1, 32'd5, 32'd0, 32'hFFFFFFFD, 32'd0, 5'd0, 32'd2, 32'd0, 1'b0, 1'b0, 1, 0};
        vt[2]  = '{OP_SUB,   1'b0, 32'd10, 32'd3, 32'd0, 32'd0, 5'd4, 32'd7, 32'd0, 1'b1, 1'b0, 1, 0};
        vt[3]  = '{OP_AND,   1'b0, 32'hF0F0, 32'hFF00, 32'd0, 32'd0, 5'd5, 32'hF000, 32'd0, 1'b1, 1'b0, 1, 0};
        vt[4]  = '{OP_OR,    1'b0, 32'hF0F0, 32'hFF00, 32'd0, 32'd0, 5'd6, 32'hFFF0, 32'd0, 1'b1, 1'b0, 1, 0};
        vt[5]  = '{OP_XOR,   1'b0, 32'hF0F0, 32'hFF00, 32'd0, 32'd0, 5'd7, 32'h0FF0, 32'd0, 1'b1, 1'b0, 1, 0};
        vt[6]  = '{OP_SLL,   1'b1, 32'd1, 32'd0, 32'h24, 32'd0, 5'd8, 32'h10, 32'd0, 1'b1, 1'b0, 1, 0};
        vt[7]  = '{OP_SRL,   1'b0, 32'h80000000, 32'd4, 32'd0, 32'd0, 5'd9, 32'h08000000, 32'd0, 1'b1, 1'b0, 1, 0};
        vt[8]  = '{OP_SRA,   1'b0, 32'h80000000, 32'd4, 32'd0, 32'd0, 5'd10, 32'hF8000000, 32'd0, 1'b1, 1'b0, 1, 0};
        vt[9]  = '{OP_SLT,   1'b0, 32'hFFFFFFFF, 32'd1, 32'd0, 32'd0, 5'd11, 32'd1, 32'd0, 1'b1, 1'b0, 1, 0};
        vt[10] = '{OP_SLTU,  1'b0, 32'hFFFFFFFF, 32'd1, 32'd0, 32'd0, 5'd12, 32'd0, 32'd0, 1'b1, 1'b0, 1, 0};
        vt[11] = '{OP_LUI,   1'b1, 32'd0, 32'd0, 32'h12345000, 32'd0, 5'd13, 32'h12345000, 32'd0, 1'b1, 1'b0, 1, 0};
        vt[12] = '{OP_AUIPC, 1'b1, 32'd0, 32'd0, 32'h1000, 32'h80000000, 5'd14, 32'h80001000, 32'd0, 1'b1, 1'b0, 1, 0};
        vt[13] = '{OP_JALR,  1'b1, 32'h80000101, 32'd0, 32'd4, 32'h80000010, 5'd1, 32'h80000014, 32'h80000104, 1'b1, 1'b0, 1, 0};
        vt[14] = '{5'd31,    1'b0, 32'd9, 32'd9, 32'd0, 32'd0, 5'd15, 32'd0, 32'd0, 1'b0, 1'b1, 1, 0};
        vt[15] = '{OP_MUL,   1'b0, 32'hFFFFFFFF, 32'd2, 32'd0, 32'd0, 5'd16, 32'hFFFFFFFE, 32'd0, 1'b1, 1'b0, 33, 32};
        vt[16] = '{OP_MULHU, 1'b0, 32'hFFFFFFFF, 32'd2, 32'd0, 32'd0, 5'd17, 32'h00000001, 32'd0, 1'b1, 1'b0, 33, 32};
        vt[17] = '{OP_MULH,  1'b0, 32'hFFFFFFFF, 32'd2, 32'd0, 32'd0, 5'd18, 32'hFFFFFFFF, 32'd0, 1'b1, 1'b0, 33, 32};
        vt[18] = '{OP_MULHSU,1'b0, 32'hFFFFFFFF, 32'd2, 32'd0, 32'd0, 5'd19, 32'hFFFFFFFF, 32'd0, 1'b1, 1'b0, 33, 32};
        vt[19] = '{OP_DIV,   1'b0, 32'hFFFFFFF9, 32'd2, 32'd0, 32'd0, 5'd20, 32'hFFFFFFFD, 32'd0, 1'b1, 1'b0, 33, 32};
        vt[20] = '{OP_REM,   1'b0, 32'hFFFFFFF9, 32'd2, 32'd0, 32'd0, 5'd21, 32'hFFFFFFFF, 32'd0, 1'b1, 1'b0, 33, 32};
        vt[21] = '{OP_DIVU,  1'b0, 32'd7, 32'd0, 32'd0, 32'd0, 5'd22, 32'hFFFFFFFF, 32'd0, 1'b1, 1'b0, 1, 0};
        vt[22] = '{OP_REMU,  1'b0, 32'd7, 32'd0, 32'd0, 32'd0, 5'd23, 32'd7, 32'd0, 1'b1, 1'b0, 1, 0};
        vt[23] = '{OP_DIV,   1'b0, 32'h80000000, 32'hFFFFFFFF, 32'd0, 32'd0, 5'd24, 32'h80000000, 32'd0, 1'b1, 1'b0, 1, 0};
        vt[24] = '{OP_REM,   1'b0, 32'h80000000, 32'hFFFFFFFF, 32'd0, 32'd0, 5'd25, 32'd0, 32'd0, 1'b1, 1'b0, 1, 0};
        vt[25] = '{OP_DIVU,  1'b0, 32'd100, 32'd7, 32'd0, 32'd0, 5'd26, 32'd14, 32'd0, 1'b1, 1'b0, 33, 32};
        vt[26] = '{OP_REMU,  1'b0, 32'd100, 32'd7, 32'd0, 32'd0, 5'd0, 32'd2, 32'd0, 1'b0, 1'b0, 33, 32};

        repeat (3) @(negedge clk);
        rst = 1'b0;
        chk("reset_out_valid", {31'b0, out_valid}, 32'd0);
        chk("reset_busy", {31'b0, busy}, 32'd0);
        chk("reset_halt", {31'b0, out_halt}, 32'd0);
        chk("reset_result", out_result, 32'd0);
        chk("reset_target", out_target, 32'd0);
        chk("reset_rd", {27'b0, out_rd}, 32'd0);
        chk("reset_in_ready", {31'b0, in_ready}, 32'd1);

        for (int i = 0; i < 27; i++) begin
            issue(vt[i].op, vt[i].ui, vt[i].s1, vt[i].s2, vt[i].imm, vt[i].pc, vt[i].rd, lat, bcnt);
            chk($sformatf("v%0d_result", i), out_result, vt[i].res);
            chk($sformatf("v%0d_target", i), out_target, vt[i].tgt);
            chk($sformatf("v%0d_wen", i), {31'b0, out_wen}, {31'b0, vt[i].wen});
            chk($sformatf("v%0d_illegal", i), {31'b0, out_illegal}, {31'b0, vt[i].ill});
            chk($sformatf("v%0d_rd", i), {27'b0, out_rd}, {27'b0, vt[i].rd});
            chk($sformatf("v%0d_latency", i), lat, vt[i].lat);
            chk($sformatf("v%0d_busy_cycles", i), bcnt, vt[i].bcnt);
            chk($sformatf("v%0d_halt", i), {31'b0, out_halt}, 32'd0);
        end

        // Backpressure: JALR result must hold for 5 cycles with in_ready low
        @(negedge clk);
        out_ready = 1'b0;
        issue(OP_JALR, 1'b1, 32'h80000101, 32'd0, 32'd4, 32'h80000010, 5'd2, lat, bcnt);
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            chk("bp_valid", {31'b0, out_valid}, 32'd1);
            chk("bp_result", out_result, 32'h80000014);
            chk("bp_target", out_target, 32'h80000104);
            chk("bp_rd", {27'b0, out_rd}, 32'd2);
            chk("bp_in_ready", {31'b0, in_ready}, 32'd0);
        end
        out_ready = 1'b1;
        @(negedge clk);
        chk("bp_drained", {31'b0, out_valid}, 32'd0);

        // EBREAK: sticky halt, later requests ignored until reset
        issue(OP_EBREAK, 1'b0, 32'd0, 32'd0, 32'd0, 32'd0, 5'd1, lat, bcnt);
        chk("ebreak_valid", {31'b0, out_valid}, 32'd1);
        chk("ebreak_halt", {31'b0, out_halt}, 32'd1);
        chk("ebreak_wen", {31'b0, out_wen}, 32'd0);
        @(negedge clk);
        in_valid = 1'b1; in_op = OP_ADD; in_use_imm = 1'b0;
        in_src1 = 32'd1; in_src2 = 32'd1; in_rd = 5'd3;
        for (int k = 0; k < 3; k++) begin
            chk("halt_in_ready", {31'b0, in_ready}, 32'd0);
            @(negedge clk);
            chk("halt_no_valid", {31'b0, out_valid}, 32'd0);
            chk("halt_sticky", {31'b0, out_halt}, 32'd1);
        end
        in_valid = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("post_rst_halt", {31'b0, out_halt}, 32'd0);
        chk("post_rst_in_ready", {31'b0, in_ready}, 32'd1);

        // Reset in the middle of a DIV aborts it silently
        in_valid = 1'b1; in_op = OP_DIV; in_use_imm = 1'b0;
        in_src1 = 32'd100; in_src2 = 32'd7; in_rd = 5'd4;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (9) @(negedge clk);
        chk("abort_busy_before", {31'b0, busy}, 32'd1);
        rst = 1'b1;
        #1;
        chk("abort_busy_async", {31'b0, busy}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        bcnt = 0;
        for (int k = 0; k < 40; k++) begin
            if (out_valid || busy) bcnt++;
            @(negedge clk);
        end
        chk("abort_no_result", bcnt, 32'd0);
        issue(OP_ADD, 1'b0, 32'd20, 32'd22, 32'd0, 32'd0, 5'd7, lat, bcnt);
        chk("after_abort_result", out_result, 32'd42);
        chk("after_abort_latency", lat, 32'd1);
        chk("after_abort_wen", {31'b0, out_wen}, 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
